// File: rtl/ldsd_encoder_pkg.sv
// rtl/ldsd_encoder_pkg.sv - shared constants, types and encode helper for ldsd_encoder
//
// Purpose: opcode/funct3 constants for RV64 LD/SD, the immediate range limit,
//          the buffered entry type, the buffer occupancy enum and the word
//          encoder function shared by the top and the skid buffer.
// Ports:   none (package).

package ldsd_encoder_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [2:0] FUNCT3_D  = 3'b011;

   // Immediates wider than this many bits cannot be represented in LD/SD.
   localparam int IMM_BITS = 12;

   typedef struct packed {
      logic        err;
      logic [31:0] instr;
   } entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // I-type layout for LD, S-type layout for SD; the unused register field is ignored.
   function automatic logic [31:0] encode_ldsd(
      input logic                is_store,
      input logic [4:0]          rd,
      input logic [4:0]          rs1,
      input logic [4:0]          rs2,
      input logic [IMM_BITS-1:0] imm
   );
      logic [31:0] word;
      if (is_store) begin
         word = {imm[11:5], rs2, rs1, FUNCT3_D, imm[4:0], OPC_STORE};
      end else begin
         word = {imm[11:0], rs1, FUNCT3_D, rd, OPC_LOAD};
      end
      return word;
   endfunction

endpackage

// File: rtl/ldsd_encoder_if.sv
// rtl/ldsd_encoder_if.sv - request/response handshake bundle for ldsd_encoder
//
// Purpose: groups the request side (in_*) and the encoded-word side (out_*).
// Ports (signals):
//   in_valid/in_ready          request handshake
//   in_is_store, in_rd, in_rs1, in_rs2, in_imm   request payload
//   out_valid/out_ready        response handshake
//   out_instr, out_err         response payload
// Modports: master = requester/consumer side, slave = encoder side.

interface ldsd_encoder_if;

   logic        in_valid;
   logic        in_ready;
   logic        in_is_store;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [63:0] in_imm;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;

   modport master (
      output in_valid, in_is_store, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err
   );

   modport slave (
      input  in_valid, in_is_store, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err
   );

endinterface

// File: rtl/ldsd_skid_buf.sv
// rtl/ldsd_skid_buf.sv - 2-entry in-order buffer of encoded entries
//
// Purpose: holds up to two {err, instr} entries; slot 0 is always the head.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   push_valid_i/push_ready_o/push_data_i   write side
//   pop_valid_o/pop_ready_i/pop_data_o      read side (head entry)

module ldsd_skid_buf
   import ldsd_encoder_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   push_valid_i,
   output logic   push_ready_o,
   input  entry_t push_data_i,
   output logic   pop_valid_o,
   input  logic   pop_ready_i,
   output entry_t pop_data_o
);

   occ_e   occ_q, occ_d;
   entry_t slot0_q, slot0_d;
   entry_t slot1_q, slot1_d;
   logic   push;
   logic   pop;

   // Ready comes from occupancy alone so it never combinationally follows pop_ready_i.
   assign push_ready_o = (occ_q != OCC_FULL);
   assign pop_valid_o  = (occ_q != OCC_EMPTY);
   assign pop_data_o   = slot0_q;

   assign push = push_valid_i && push_ready_o;
   assign pop  = pop_valid_o && pop_ready_i;

   always_comb begin
      occ_d   = occ_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               slot0_d = push_data_i;
               occ_d   = OCC_ONE;
            end
         end
         OCC_ONE: begin
            case ({push, pop})
               2'b10: begin
                  slot1_d = push_data_i;
                  occ_d   = OCC_FULL;
               end
               2'b01: begin
                  occ_d = OCC_EMPTY;
               end
               2'b11: begin
                  // Head leaves and the new entry becomes head; occupancy unchanged.
                  slot0_d = push_data_i;
               end
               default: begin
                  occ_d = OCC_ONE;
               end
            endcase
         end
         OCC_FULL: begin
            // No push is possible here because push_ready_o is low.
            if (pop) begin
               slot0_d = slot1_q;
               occ_d   = OCC_ONE;
            end
         end
         default: begin
            occ_d = OCC_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q   <= OCC_EMPTY;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         occ_q   <= occ_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

endmodule

// File: rtl/ldsd_encoder.sv
// rtl/ldsd_encoder.sv - RV64 LD/SD instruction word encoder with 2-entry output buffer
//
// Purpose: encodes an LD or SD request into a 32-bit RV64 word, registers it in
//          a 2-entry in-order buffer and counts delivered words.
// Ports:
//   clk        sole clock
//   reset      synchronous active-high reset
//   bus        ldsd_encoder_if.slave: in_* request, out_* encoded word
//   enc_count  number of words delivered on the output (wraps)
// Parameters: CNT_W width of enc_count.
// Configuration: define IMM_RANGE_CHECK_EN to flag immediates with bits above
//                bit 11 set via out_err; otherwise out_err is tied to 0.

module ldsd_encoder
   import ldsd_encoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   ldsd_encoder_if.slave    bus,
   output logic [CNT_W-1:0] enc_count
);

   entry_t           req_entry;
   entry_t           head_entry;
   logic             head_valid;
   logic             out_pop;
   logic [CNT_W-1:0] enc_count_q, enc_count_d;

   always_comb begin
      req_entry.instr = encode_ldsd(bus.in_is_store, bus.in_rd, bus.in_rs1,
                                    bus.in_rs2, bus.in_imm[IMM_BITS-1:0]);
`ifdef IMM_RANGE_CHECK_EN
      req_entry.err   = |bus.in_imm[63:IMM_BITS];
`else
      req_entry.err   = 1'b0;
`endif
   end

   ldsd_skid_buf u_buf (
      .clk          (clk),
      .reset        (reset),
      .push_valid_i (bus.in_valid),
      .push_ready_o (bus.in_ready),
      .push_data_i  (req_entry),
      .pop_valid_o  (head_valid),
      .pop_ready_i  (bus.out_ready),
      .pop_data_o   (head_entry)
   );

   assign bus.out_valid = head_valid;
   assign bus.out_instr = head_entry.instr;

`ifdef IMM_RANGE_CHECK_EN
   assign bus.out_err = head_entry.err;
`else
   // Without the range check the high immediate bits and stored err bit are don't-care.
   logic unused_imm_hi;
   logic unused_err;
   assign unused_imm_hi = ^bus.in_imm[63:IMM_BITS];
   assign unused_err    = head_entry.err;
   assign bus.out_err   = 1'b0;
`endif

   assign out_pop = head_valid && bus.out_ready;

   always_comb begin
      enc_count_d = enc_count_q;
      if (out_pop) begin
         enc_count_d = enc_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enc_count_q <= '0;
      end else begin
         enc_count_q <= enc_count_d;
      end
   end

   assign enc_count = enc_count_q;

endmodule

// File: tb/tb_ldsd_encoder.sv
// tb/tb_ldsd_encoder.sv - directed self-checking bench for ldsd_encoder

module tb_ldsd_encoder;

   logic        clk;
   logic        reset;
   logic [15:0] enc_count;
   logic [3:0]  enc_count4;

   int checks;
   int errors;

   ldsd_encoder_if bus ();
   ldsd_encoder_if bus4 ();

   ldsd_encoder #(.CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .enc_count (enc_count)
   );

   ldsd_encoder #(.CNT_W(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus4),
      .enc_count (enc_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic is_store, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] imm);
      bus.in_valid    = 1'b1;
      bus.in_is_store = is_store;
      bus.in_rd       = rd;
      bus.in_rs1      = rs1;
      bus.in_rs2      = rs2;
      bus.in_imm      = imm;
   endtask

   logic [31:0] word;
   logic [11:0] s_imm;
   logic        err_exp;

   initial begin
      checks = 0;
      errors = 0;
`ifdef IMM_RANGE_CHECK_EN
      err_exp = 1'b1;
`else
      err_exp = 1'b0;
`endif
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_is_store = 1'b0; bus.in_rd = '0;
      bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b1;
      bus4.in_valid = 1'b0; bus4.in_is_store = 1'b0; bus4.in_rd = 5'd1;
      bus4.in_rs1 = 5'd2; bus4.in_rs2 = '0; bus4.in_imm = 64'h4; bus4.out_ready = 1'b1;
      tick();
      tick();

      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_instr", bus.out_instr, 0);
      check("rst_out_err", bus.out_err, 0);
      check("rst_enc_count", enc_count, 0);
      reset = 1'b0;

      // LD x5, 0x10(x2)
      drive(1'b0, 5'd5, 5'd2, 5'd0, 64'h10);
      tick();
      check("ld_valid", bus.out_valid, 1);
      check("ld_instr", bus.out_instr, 64'h01013283);
      check("ld_err", bus.out_err, 0);
      bus.in_valid = 1'b0;
      tick();
      check("ld_count", enc_count, 1);
      check("ld_drained", bus.out_valid, 0);

      // SD x7, 0x7FF(x3)
      drive(1'b1, 5'd0, 5'd3, 5'd7, 64'h7FF);
      tick();
      check("sd_instr", bus.out_instr, 64'h7E71BFA3);
      word  = bus.out_instr;
      s_imm = {word[31:25], word[11:7]};
      check("sd_imm_extract", {52'd0, s_imm}, 64'h7FF);
      bus.in_valid = 1'b0;
      tick();
      check("sd_count", enc_count, 2);

      // Backpressure: A, B accepted, C refused
      bus.out_ready = 1'b0;
      drive(1'b0, 5'd1, 5'd1, 5'd0, 64'h1);
      check("bp_ready_a", bus.in_ready, 1);
      tick();
      drive(1'b1, 5'd0, 5'd5, 5'd4, 64'h20);
      check("bp_ready_b", bus.in_ready, 1);
      tick();
      drive(1'b0, 5'd3, 5'd6, 5'd0, 64'hABC);
      check("bp_ready_c", bus.in_ready, 0);
      tick();
      check("bp_hold_head", bus.out_instr, 64'h0010B083);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_still_full", bus.in_ready, 0);
      check("bp_count", enc_count, 2);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("pop_same_cycle_ready", bus.in_ready, 0);
      tick();
      check("bp_head_b", bus.out_instr, 64'h0242B023);
      check("bp_ready_after_pop", bus.in_ready, 1);
      check("bp_count_a", enc_count, 3);
      tick();
      check("bp_empty", bus.out_valid, 0);
      check("bp_count_b", enc_count, 4);

      // Simultaneous push and pop at occupancy 1
      drive(1'b0, 5'd3, 5'd6, 5'd0, 64'hABC);
      tick();
      check("c_instr", bus.out_instr, 64'hABC33183);
      drive(1'b0, 5'd10, 5'd11, 5'd0, 64'h0);
      tick();
      check("pp_head_d", bus.out_instr, 64'h0005B503);
      check("pp_valid", bus.out_valid, 1);
      check("pp_count", enc_count, 5);
      bus.in_valid = 1'b0;
      tick();
      check("pp_drained", bus.out_valid, 0);
      check("pp_count_d", enc_count, 6);

      // Out-of-range immediate
      drive(1'b0, 5'd5, 5'd2, 5'd0, 64'h1000);
      tick();
      check("rng_instr", bus.out_instr, 64'h00013283);
      check("rng_err", bus.out_err, {63'd0, err_exp});
      bus.in_valid = 1'b0;
      tick();
      check("rng_count", enc_count, 7);

      // Reset with occupancy 2
      bus.out_ready = 1'b0;
      drive(1'b0, 5'd1, 5'd1, 5'd0, 64'h1);
      tick();
      drive(1'b1, 5'd0, 5'd5, 5'd4, 64'h20);
      tick();
      bus.in_valid = 1'b0;
      check("pre_rst_full", bus.in_ready, 0);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_count", enc_count, 0);
      check("mid_rst_ready", bus.in_ready, 1);
      check("mid_rst_instr", bus.out_instr, 0);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("post_rst_valid", bus.out_valid, 0);
      check("post_rst_count", enc_count, 0);

      // Counter wrap on the CNT_W=4 instance
      bus4.in_valid = 1'b1;
      repeat (17) tick();
      check("wrap_16", {60'd0, enc_count4}, 0);
      bus4.in_valid = 1'b0;
      tick();
      check("wrap_17", {60'd0, enc_count4}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ldsd_encoder.md
LDSD_ENCODER -- requirements
Module: ldsd_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the encoded-instruction counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  encoder can accept the request.
REQ-006 SHALL have port in_is_store  input  1  1 = SD, 0 = LD.
REQ-007 SHALL have port in_rd  input  5  destination register, LD only.
REQ-008 SHALL have port in_rs1  input  5  base register.
REQ-009 SHALL have port in_rs2  input  5  source register, SD only.
REQ-010 SHALL have port in_imm  input  64  offset in the same 64-bit zero-extended form the immediate extractor produces.
REQ-011 SHALL have port out_valid  output  1  out_instr is valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts.
REQ-013 SHALL have port out_instr  output  32  encoded RV64 instruction word.
REQ-014 SHALL have port out_err  output  1  immediate out of range; qualified by out_valid.
REQ-015 SHALL have port enc_count  output  CNT_W  number of instructions delivered on the output.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 LD encoding SHALL be {in_imm[11:0], rs1, 3'b011, rd, 7'b0000011}; rs2 is ignored.
REQ-018 SD encoding SHALL be {in_imm[11:5], rs2, rs1, 3'b011, in_imm[4:0], 7'b0100011}; rd is ignored.
REQ-019 Encoding SHALL be registered; an accepted request SHALL appear on out_valid in the next cycle if the buffer is empty (latency 1).
REQ-020 The block SHALL hold a 2-entry in-order buffer (slots 0/1, occupancy 0..2); out_* SHALL be driven from the head entry only.
REQ-021 in_ready SHALL be 1 when occupancy < 2 and SHALL depend only on registered state, not on out_ready.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; at occupancy 2 a pop SHALL raise in_ready the next cycle, not the same cycle.
REQ-023 out_valid SHALL stay asserted and out_instr/out_err SHALL stay stable until the transfer completes.
REQ-024 enc_count SHALL increment by 1 on each output transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 A request with in_valid low SHALL NOT change any state.

Reset
REQ-026 While reset is high at a clock edge, occupancy SHALL become 0; out_valid = 0, in_ready = 1 from the next cycle, out_instr = 0, out_err = 0, enc_count = 0.
REQ-027 Reset mid-operation SHALL discard buffered entries without an output transfer and without counting them.

Configuration
REQ-028 With IMM_RANGE_CHECK_EN defined, out_err SHALL be set for an entry whose in_imm[63:12] != 0; the word SHALL still be encoded from in_imm[11:0] and SHALL still count.
REQ-029 Without IMM_RANGE_CHECK_EN, out_err SHALL be constant 0 and in_imm[63:12] SHALL be ignored.

Structure
REQ-030 A shared package SHALL hold OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, FUNCT3_D = 3'b011 and the range-check limit of 12 bits.
REQ-031 The 2-entry buffer SHALL be a sub-module named ldsd_skid_buf, holding {err, instr[31:0]}.

Verification
REQ-032 LD rd=5, rs1=2, imm=0x10, out_ready=1 -> next cycle out_valid=1, out_instr=0x01013283, enc_count=1.
REQ-033 SD rs2=7, rs1=3, imm=0x7FF -> out_instr=0x7E71BFA3; feeding it to the immediate extractor returns 0x7FF.
REQ-034 out_ready=0, three back-to-back requests -> two accepted, in_ready=0 on the third; after out_ready=1, outputs appear in order with no loss or duplication.
REQ-035 IMM_RANGE_CHECK_EN defined, LD imm=0x1000 -> out_err=1, imm field 0x000; without the macro -> out_err=0.
REQ-036 Reset asserted with occupancy 2 -> out_valid=0, enc_count=0, in_ready=1 the cycle after; CNT_W=4, 17 transfers -> enc_count=1.
